// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit load/store CPU: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_LD  = 4'hB;
    localparam logic [3:0] OP_ST  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_JZ  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm/addr
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes ADD..SHR; produces result plus Z/C flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       z,
    output logic       c
);

    // Result and carry/borrow selection by opcode; non-ALU opcodes pass a through
    always_comb begin
        y = a;
        c = 1'b0;
        case (op)
            OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                y = a - b;
                c = (a < b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = {a[6:0], 1'b0};
                c = a[7];
            end
            OP_SHR: begin
                y = {1'b0, a[7:1]};
                c = a[0];
            end
            default: ;
        endcase
    end

    assign z = (y == 8'h00);

endmodule

// File: rtl/cpu.sv
// Multicycle 8-bit Harvard CPU: FETCH/EXEC/HALT FSM, four registers, Z/C
// flags, instruction ROM and a 256x8 data RAM.
module cpu
    import cpu_pkg::*;
#(
    parameter string PROG_FILE  = "program.hex",
    parameter int    IMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);

    logic [7:0]  pc;
    logic [15:0] ir;
    state_t      state;
    state_t      state_next;
    logic [7:0]  regs [0:3];
    logic        flag_z;
    logic        flag_c;
    logic        halted;
    logic [15:0] imem [0:IMEM_DEPTH-1];
    logic [7:0]  dmem [0:255];

    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic [15:0] fetch_word;
    logic [7:0]  alu_y;
    logic        alu_z;
    logic        alu_c;
    logic [7:0]  wdata;
    logic        fetch_en;
    logic        reg_we;
    logic        flag_we;
    logic        mem_we;
    logic        pc_load;
    logic        halt_set;

    // ROM contents default to zero (NOP)
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = 16'h0000;
    end

    assign opcode     = ir[OPC_MSB:OPC_LSB];
    assign rd         = ir[RD_MSB:RD_LSB];
    assign rs         = ir[RS_MSB:RS_LSB];
    assign imm        = ir[IMM_MSB:IMM_LSB];
    assign fetch_word = (32'(pc) < IMEM_DEPTH) ? imem[pc] : 16'h0000;

    cpu_alu u_alu (
        .op (opcode),
        .a  (regs[rd]),
        .b  (regs[rs]),
        .y  (alu_y),
        .z  (alu_z),
        .c  (alu_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // FSM next-state: HLT is the only way into the absorbing HALT state
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: state_next = S_EXEC;
            S_EXEC:  state_next = (opcode == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // FSM outputs: datapath strobes decoded from state and opcode
    always_comb begin
        fetch_en = 1'b0;
        reg_we   = 1'b0;
        flag_we  = 1'b0;
        mem_we   = 1'b0;
        pc_load  = 1'b0;
        halt_set = 1'b0;
        if (state == S_FETCH) begin
            fetch_en = 1'b1;
        end else if (state == S_EXEC) begin
            case (opcode)
                OP_LDI, OP_MOV, OP_LD: reg_we = 1'b1;
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                OP_NOT, OP_SHL, OP_SHR: begin
                    reg_we  = 1'b1;
                    flag_we = 1'b1;
                end
                OP_ST:   mem_we   = 1'b1;
                OP_JMP:  pc_load  = 1'b1;
                OP_JZ:   pc_load  = flag_z;
                OP_HLT:  halt_set = 1'b1;
                default: ;
            endcase
        end
    end

    // Register write-back source; data RAM read is combinational during EXEC
    always_comb begin
        case (opcode)
            OP_LDI:  wdata = imm;
            OP_MOV:  wdata = regs[rs];
            OP_LD:   wdata = dmem[imm];
            default: wdata = alu_y;
        endcase
    end

    // Architectural state: pc, ir, registers, flags, halt marker
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= 8'h00;
            ir     <= 16'h0000;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else begin
            if (fetch_en) begin
                ir <= fetch_word;
                pc <= pc + 8'd1;
            end
            if (pc_load) pc <= imm;
            if (reg_we) regs[rd] <= wdata;
            if (flag_we) begin
                flag_z <= alu_z;
                flag_c <= alu_c;
            end
            if (halt_set) halted <= 1'b1;
        end
    end

    // Data RAM: cleared as a whole by reset, written on the EXEC edge of ST
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
        end else if (mem_we) begin
            dmem[imm] <= regs[rd];
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: programs are poked into the ROM hierarchically,
// results are sampled on the falling edge through the internal signal names.
module tb_cpu;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    cpu #(.PROG_FILE(""), .IMEM_DEPTH(256)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) dut.imem[i] = 16'h0000;
    endtask

    // Reset spans exactly one rising edge; first fetch is on the next edge
    task automatic apply_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_mem_prog();
        clear_prog();
        dut.imem[0] = enc(OP_LDI, 2'd2, 2'd0, 8'hA5);
        dut.imem[1] = enc(OP_ST,  2'd2, 2'd0, 8'h10);
        dut.imem[2] = enc(OP_LD,  2'd3, 2'd0, 8'h10);
        dut.imem[3] = enc(OP_NOT, 2'd3, 2'd0, 8'h00);
        dut.imem[4] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
    endtask

    task automatic test_reset();
        clear_prog();
        apply_reset();
        vectors++; if (dut.pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %h want 00", dut.pc); end
        vectors++; if (dut.ir !== 16'h0000) begin miscompares++; $display("FAIL rst_ir got %h want 0000", dut.ir); end
        vectors++; if (dut.state !== S_FETCH) begin miscompares++; $display("FAIL rst_state got %0d want %0d", dut.state, S_FETCH); end
        vectors++; if ({dut.flag_z, dut.flag_c, dut.halted} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {dut.flag_z, dut.flag_c, dut.halted}); end
        run(2);
        vectors++; if (dut.pc !== 8'h01) begin miscompares++; $display("FAIL nop_pc2 got %h want 01", dut.pc); end
        run(1);
        vectors++; if (dut.pc !== 8'h02) begin miscompares++; $display("FAIL nop_pc3 got %h want 02", dut.pc); end
        run(1);
        vectors++; if (dut.pc !== 8'h02) begin miscompares++; $display("FAIL nop_pc4 got %h want 02", dut.pc); end
        run(508);
        vectors++; if (dut.pc !== 8'h00) begin miscompares++; $display("FAIL nop_wrap got %h want 00", dut.pc); end
        vectors++; if ({dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]} !== 32'h0) begin miscompares++; $display("FAIL nop_regs got %h want 0", {dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]}); end
        $display("test_reset: pc=%h after 512 cycles", dut.pc);
    endtask

    task automatic test_alu();
        clear_prog();
        dut.imem[0] = enc(OP_LDI, 2'd0, 2'd0, 8'h7F);
        dut.imem[1] = enc(OP_LDI, 2'd1, 2'd0, 8'h01);
        dut.imem[2] = enc(OP_ADD, 2'd0, 2'd1, 8'h00);
        dut.imem[3] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        apply_reset();
        run(7);
        vectors++; if (dut.pc !== 8'h04) begin miscompares++; $display("FAIL alu_pc7 got %h want 04", dut.pc); end
        run(1);
        vectors++; if (dut.regs[0] !== 8'h80) begin miscompares++; $display("FAIL alu_r0 got %h want 80", dut.regs[0]); end
        vectors++; if ({dut.flag_z, dut.flag_c} !== 2'b00) begin miscompares++; $display("FAIL alu_zc got %b want 00", {dut.flag_z, dut.flag_c}); end
        vectors++; if (dut.halted !== 1'b1) begin miscompares++; $display("FAIL alu_halted got %b want 1", dut.halted); end
        run(10);
        vectors++; if (dut.pc !== 8'h04) begin miscompares++; $display("FAIL alu_pc_frozen got %h want 04", dut.pc); end
        vectors++; if (dut.state !== S_HALT) begin miscompares++; $display("FAIL alu_state got %0d want %0d", dut.state, S_HALT); end
        $display("test_alu: r0=%h z=%b c=%b", dut.regs[0], dut.flag_z, dut.flag_c);
    endtask

    task automatic test_carry();
        clear_prog();
        dut.imem[0] = enc(OP_LDI, 2'd0, 2'd0, 8'hFF);
        dut.imem[1] = enc(OP_LDI, 2'd1, 2'd0, 8'h01);
        dut.imem[2] = enc(OP_ADD, 2'd0, 2'd1, 8'h00);
        dut.imem[3] = enc(OP_SUB, 2'd1, 2'd0, 8'h00);
        dut.imem[4] = enc(OP_SHR, 2'd1, 2'd0, 8'h00);
        dut.imem[5] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        apply_reset();
        run(6);
        vectors++; if (dut.regs[0] !== 8'h00) begin miscompares++; $display("FAIL add_r0 got %h want 00", dut.regs[0]); end
        vectors++; if ({dut.flag_z, dut.flag_c} !== 2'b11) begin miscompares++; $display("FAIL add_zc got %b want 11", {dut.flag_z, dut.flag_c}); end
        run(2);
        vectors++; if (dut.regs[1] !== 8'h01) begin miscompares++; $display("FAIL sub_r1 got %h want 01", dut.regs[1]); end
        vectors++; if ({dut.flag_z, dut.flag_c} !== 2'b00) begin miscompares++; $display("FAIL sub_zc got %b want 00", {dut.flag_z, dut.flag_c}); end
        run(2);
        vectors++; if (dut.regs[1] !== 8'h00) begin miscompares++; $display("FAIL shr_r1 got %h want 00", dut.regs[1]); end
        vectors++; if ({dut.flag_z, dut.flag_c} !== 2'b11) begin miscompares++; $display("FAIL shr_zc got %b want 11", {dut.flag_z, dut.flag_c}); end
        $display("test_carry: r0=%h r1=%h z=%b c=%b", dut.regs[0], dut.regs[1], dut.flag_z, dut.flag_c);
    endtask

    task automatic test_memory();
        load_mem_prog();
        apply_reset();
        run(4);
        vectors++; if (dut.dmem[8'h10] !== 8'hA5) begin miscompares++; $display("FAIL st_dmem got %h want a5", dut.dmem[8'h10]); end
        run(4);
        vectors++; if (dut.regs[3] !== 8'h5A) begin miscompares++; $display("FAIL not_r3 got %h want 5a", dut.regs[3]); end
        vectors++; if ({dut.flag_z, dut.flag_c} !== 2'b00) begin miscompares++; $display("FAIL not_zc got %b want 00", {dut.flag_z, dut.flag_c}); end
        $display("test_memory: dmem[10]=%h r3=%h", dut.dmem[8'h10], dut.regs[3]);
    endtask

    task automatic test_branch();
        int cycles;
        clear_prog();
        dut.imem[0] = enc(OP_LDI, 2'd0, 2'd0, 8'd3);
        dut.imem[1] = enc(OP_LDI, 2'd1, 2'd0, 8'd1);
        dut.imem[2] = enc(OP_SUB, 2'd0, 2'd1, 8'h00);
        dut.imem[3] = enc(OP_JZ,  2'd0, 2'd0, 8'd5);
        dut.imem[4] = enc(OP_JMP, 2'd0, 2'd0, 8'd2);
        dut.imem[5] = enc(OP_HLT, 2'd0, 2'd0, 8'h00);
        apply_reset();
        cycles = 0;
        while (dut.halted !== 1'b1 && cycles < 40) begin
            run(1);
            cycles++;
        end
        vectors++; if (dut.halted !== 1'b1) begin miscompares++; $display("FAIL loop_halt got %b want 1 within 40 cycles", dut.halted); end
        vectors++; if (cycles !== 22) begin miscompares++; $display("FAIL loop_cycles got %0d want 22", cycles); end
        vectors++; if (dut.regs[0] !== 8'h00) begin miscompares++; $display("FAIL loop_r0 got %h want 00", dut.regs[0]); end
        vectors++; if (dut.pc !== 8'h06) begin miscompares++; $display("FAIL loop_pc got %h want 06", dut.pc); end
        $display("test_branch: halted after %0d cycles, r0=%h", cycles, dut.regs[0]);
    endtask

    task automatic test_reset_mid();
        load_mem_prog();
        apply_reset();
        run(5);
        vectors++; if (dut.state !== S_EXEC) begin miscompares++; $display("FAIL mid_state got %0d want %0d", dut.state, S_EXEC); end
        vectors++; if (dut.dmem[8'h10] !== 8'hA5) begin miscompares++; $display("FAIL mid_pre_dmem got %h want a5", dut.dmem[8'h10]); end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        vectors++; if (dut.pc !== 8'h00) begin miscompares++; $display("FAIL mid_pc got %h want 00", dut.pc); end
        vectors++; if ({dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]} !== 32'h0) begin miscompares++; $display("FAIL mid_regs got %h want 0", {dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]}); end
        vectors++; if (dut.dmem[8'h10] !== 8'h00) begin miscompares++; $display("FAIL mid_dmem got %h want 00", dut.dmem[8'h10]); end
        vectors++; if ({dut.flag_z, dut.flag_c, dut.halted} !== 3'b000) begin miscompares++; $display("FAIL mid_flags got %b want 000", {dut.flag_z, dut.flag_c, dut.halted}); end
        run(8);
        vectors++; if (dut.dmem[8'h10] !== 8'hA5) begin miscompares++; $display("FAIL rerun_dmem got %h want a5", dut.dmem[8'h10]); end
        vectors++; if (dut.regs[3] !== 8'h5A) begin miscompares++; $display("FAIL rerun_r3 got %h want 5a", dut.regs[3]); end
        run(2);
        vectors++; if (dut.halted !== 1'b1) begin miscompares++; $display("FAIL rerun_halted got %b want 1", dut.halted); end
        $display("test_reset_mid: rerun r3=%h halted=%b", dut.regs[3], dut.halted);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        test_reset();
        test_alu();
        test_carry();
        test_memory();
        test_branch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
